// File: rtl/apb_dual_master_sequencer.sv
// apb_dual_master_sequencer: round-robin sequencer for two requesters sharing one APB bus
// toward three slaves (one-hot Pselx). Address decode, IDLE -> SETUP -> ACCESS protocol,
// registered read data returned to the owning requester.
// Optional feature: define APB_PREADY_EN to add the Pready port, wait states and the
// WAIT_MAX access timeout.
module apb_dual_master_sequencer #(
    parameter int unsigned ADDR_W   = 32,
`ifdef APB_PREADY_EN
    parameter int unsigned WAIT_MAX = 15,
`endif
    parameter int unsigned DATA_W   = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic              req0_err,
    output logic [DATA_W-1:0] req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic              req1_err,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              Pwrite,
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
`ifdef APB_PREADY_EN
    input  logic              Pready,
`endif
    input  logic [DATA_W-1:0] Prdata
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StErr} state_e;

`ifdef APB_PREADY_EN
    localparam int unsigned WaitW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
    logic [WaitW-1:0] wait_q, wait_d;
`endif

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic [2:0]        pselx_q, pselx_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic [1:0]        req_valid;
    logic [1:0]        elig;
    logic              grant;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_pselx;

    // Three 64 MiB windows starting at 0x8000_0000; anything else selects no slave.
    function automatic logic [2:0] decode(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] region;
        region = addr >> 26;
        if (region == ADDR_W'(32)) return 3'b001;
        if (region == ADDR_W'(33)) return 3'b010;
        if (region == ADDR_W'(34)) return 3'b100;
        return 3'b000;
    endfunction

    assign req_valid = {req1_valid, req0_valid};

    // Eligible requesters: a requester is masked in its done cycle and while its own
    // transfer is completing, so a still-held valid never re-issues the same request.
    always_comb begin
        elig = req_valid & ~done_q;
        if (state_q == StAccess) begin
            elig[owner_q] = 1'b0;
        end
    end

    // Round-robin pick: on contention the requester other than last_grant wins.
    always_comb begin
        grant     = (elig == 2'b11) ? ~last_grant_q : elig[1];
        sel_write = grant ? req1_write : req0_write;
        sel_addr  = grant ? req1_addr  : req0_addr;
        sel_wdata = grant ? req1_wdata : req0_wdata;
        sel_pselx = decode(sel_addr);
    end

    // Next-state and registered-output logic for the transfer sequencer.
    always_comb begin
        logic arb;
        logic complete;
        logic fail;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        pselx_d      = pselx_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        done_d       = 2'b00;
        err_d        = 2'b00;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
`ifdef APB_PREADY_EN
        wait_d       = wait_q;
`endif
        arb          = 1'b0;
        complete     = 1'b0;
        fail         = 1'b0;

        unique case (state_q)
            StIdle: begin
                arb = 1'b1;
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
`ifdef APB_PREADY_EN
                wait_d    = '0;
`endif
            end
            StAccess: begin
`ifdef APB_PREADY_EN
                if (Pready) begin
                    complete = 1'b1;
                end else if (wait_q == WaitW'(WAIT_MAX)) begin
                    complete = 1'b1;
                    fail     = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`else
                complete = 1'b1;
`endif
                if (complete) begin
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = fail;
                    // Timed-out reads leave the requester's read data untouched.
                    if (!pwrite_q && !fail) begin
                        if (owner_q) begin
                            rdata1_d = Prdata;
                        end else begin
                            rdata0_d = Prdata;
                        end
                    end
                    state_d   = StIdle;
                    pselx_d   = 3'b000;
                    penable_d = 1'b0;
                    arb       = 1'b1;
                end
            end
            StErr: begin
                done_d[owner_q] = 1'b1;
                err_d[owner_q]  = 1'b1;
                state_d         = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (arb && (elig != 2'b00)) begin
            last_grant_d = grant;
            owner_d      = grant;
            penable_d    = 1'b0;
            if (sel_pselx != 3'b000) begin
                state_d  = StSetup;
                pselx_d  = sel_pselx;
                pwrite_d = sel_write;
                paddr_d  = sel_addr;
                pwdata_d = sel_wdata;
            end else begin
                state_d = StErr;
                pselx_d = 3'b000;
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            pselx_q      <= 3'b000;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            done_q       <= 2'b00;
            err_q        <= 2'b00;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
`ifdef APB_PREADY_EN
            wait_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            pselx_q      <= pselx_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            done_q       <= done_d;
            err_q        <= err_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
`ifdef APB_PREADY_EN
            wait_q       <= wait_d;
`endif
        end
    end

    assign Pselx      = pselx_q;
    assign Penable    = penable_q;
    assign Pwrite     = pwrite_q;
    assign Paddr      = paddr_q;
    assign Pwdata     = pwdata_q;
    assign req0_done  = done_q[0];
    assign req0_err   = err_q[0];
    assign req0_rdata = rdata0_q;
    assign req1_done  = done_q[1];
    assign req1_err   = err_q[1];
    assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_apb_dual_master_sequencer.sv
// Bench for apb_dual_master_sequencer: directed requests with a slot-schedule reference
// model checked every cycle, plus hand-computed expectations at key cycles.
module tb_apb_dual_master_sequencer;

    localparam int NSLOT = 2048;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic        req0_done, req0_err, req1_done, req1_err;
    logic [31:0] req0_rdata, req1_rdata;
    logic        Pwrite, Penable;
    logic [2:0]  Pselx;
    logic [31:0] Paddr, Pwdata, Prdata;
`ifdef APB_PREADY_EN
    logic        pready = 1'b1;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    apb_dual_master_sequencer dut (
        .Hclk       (Hclk),
        .Hresetn    (Hresetn),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_done  (req0_done),
        .req0_err   (req0_err),
        .req0_rdata (req0_rdata),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_done  (req1_done),
        .req1_err   (req1_err),
        .req1_rdata (req1_rdata),
        .Pwrite     (Pwrite),
        .Pselx      (Pselx),
        .Penable    (Penable),
        .Paddr      (Paddr),
        .Pwdata     (Pwdata),
`ifdef APB_PREADY_EN
        .Pready     (pready),
`endif
        .Prdata     (Prdata)
    );

    always #5 Hclk = ~Hclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: expected outputs per slot (slot s = interval after rising edge s).
    bit [2:0]  x_psel   [NSLOT];
    bit        x_pen    [NSLOT];
    bit        x_pwrite [NSLOT];
    bit [31:0] x_paddr  [NSLOT];
    bit [31:0] x_pwdata [NSLOT];
    bit        x_done   [2][NSLOT];
    bit        x_err    [2][NSLOT];
    bit [31:0] x_rd     [2];
    int        ecnt      = 0;
    int        next_arb  = 0;
    int        comp_edge = -1;
    int        comp_own  = 0;
    bit        comp_read = 0;
    int        last      = 1;

    function automatic bit [2:0] slave_of(input bit [31:0] a);
        if (a >= 32'h8000_0000 && a <= 32'h83FF_FFFF) return 3'b001;
        if (a >= 32'h8400_0000 && a <= 32'h87FF_FFFF) return 3'b010;
        if (a >= 32'h8800_0000 && a <= 32'h8BFF_FFFF) return 3'b100;
        return 3'b000;
    endfunction

    // A grant at edge e: setup in slot e, access in slot e+1, done in slot e+2, next
    // arbitration at edge e+2. A decode error: done+err in slot e+1, next arbitration e+2.
    task automatic model_step();
        int e, w;
        bit el0, el1, wr;
        bit [31:0] a, d;
        bit [2:0] sel;
        e = ecnt;
        if (!Hresetn) begin
            for (int s = e; s < e + 4 && s < NSLOT; s++) begin
                x_psel[s] = 0; x_pen[s] = 0; x_pwrite[s] = 0; x_paddr[s] = 0; x_pwdata[s] = 0;
                x_done[0][s] = 0; x_done[1][s] = 0; x_err[0][s] = 0; x_err[1][s] = 0;
            end
            x_rd[0] = 0; x_rd[1] = 0; last = 1; next_arb = e + 1; comp_edge = -1;
        end else begin
            if (comp_edge == e && comp_read) x_rd[comp_own] = Prdata;
            if (e >= next_arb && e + 2 < NSLOT) begin
                el0 = req0_valid && !(e > 0 && x_done[0][e-1]) && !(comp_edge == e && comp_own == 0);
                el1 = req1_valid && !(e > 0 && x_done[1][e-1]) && !(comp_edge == e && comp_own == 1);
                if (el0 || el1) begin
                    w = (el0 && el1) ? 1 - last : (el0 ? 0 : 1);
                    last = w;
                    a  = w ? req1_addr  : req0_addr;
                    d  = w ? req1_wdata : req0_wdata;
                    wr = w ? req1_write : req0_write;
                    sel = slave_of(a);
                    if (sel != 0) begin
                        for (int s = e; s <= e + 1; s++) begin
                            x_psel[s] = sel; x_pwrite[s] = wr; x_paddr[s] = a; x_pwdata[s] = d;
                            x_pen[s] = (s == e + 1);
                        end
                        x_done[w][e+2] = 1;
                        comp_edge = e + 2; comp_own = w; comp_read = !wr;
                    end else begin
                        x_done[w][e+1] = 1;
                        x_err[w][e+1]  = 1;
                    end
                    next_arb = e + 2;
                end else begin
                    next_arb = e + 1;
                end
            end
        end
        ecnt++;
    endtask

    initial forever begin
        @(posedge Hclk);
        model_step();
    end

    // Per-cycle compare against the model.
    initial forever begin
        int s;
        @(negedge Hclk);
        if (ecnt > 0 && ecnt <= NSLOT) begin
            s = ecnt - 1;
            chk("cyc_pselx", Pselx, x_psel[s]);
            chk("cyc_penable", Penable, x_pen[s]);
            chk("cyc_done0", req0_done, x_done[0][s]);
            chk("cyc_done1", req1_done, x_done[1][s]);
            chk("cyc_err0", req0_err, x_err[0][s]);
            chk("cyc_err1", req1_err, x_err[1][s]);
            chk("cyc_rdata0", req0_rdata, x_rd[0]);
            chk("cyc_rdata1", req1_rdata, x_rd[1]);
            if (x_psel[s] != 0) begin
                chk("cyc_pwrite", Pwrite, x_pwrite[s]);
                chk("cyc_paddr", Paddr, x_paddr[s]);
                chk("cyc_pwdata", Pwdata, x_pwdata[s]);
            end
        end
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    // One request from idle; checks done latency, error flag and read data.
    task automatic xfer(input int r, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input bit exp_err, input string nm);
        int n;
        bit got;
        Prdata = rd;
        if (r == 0) begin
            req0_valid = 1; req0_write = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = 1; req1_write = wr; req1_addr = a; req1_wdata = d;
        end
        n = 0;
        got = 0;
        while (!got && n < 12) begin
            @(negedge Hclk);
            n++;
            got = (r == 0) ? req0_done : req1_done;
        end
        chk({nm, "_seen"}, got, 1);
        if (got) begin
            chk({nm, "_lat"}, n, exp_err ? 3 : 4);
            chk({nm, "_err"}, (r == 0) ? req0_err : req1_err, exp_err);
            if (!wr && !exp_err) chk({nm, "_rdata"}, (r == 0) ? req0_rdata : req1_rdata, rd);
        end
        tick();
        if (r == 0) req0_valid = 0;
        else req1_valid = 0;
    endtask

    bit [2:0] t3_psel [8] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b100, 3'b100, 3'b001, 3'b001};
    bit       t3_pen  [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    bit       t3_d0   [8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    bit       t3_d1   [8] = '{0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        Hresetn = 0;
        req0_valid = 0; req0_write = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_write = 0; req1_addr = 0; req1_wdata = 0;
        Prdata = 0;
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        chk("rst_pselx", Pselx, 0);
        chk("rst_penable", Penable, 0);
        chk("rst_pwrite", Pwrite, 0);
        chk("rst_paddr", Paddr, 0);
        chk("rst_pwdata", Pwdata, 0);
        chk("rst_done", {req1_done, req0_done, req1_err, req0_err}, 0);
        chk("rst_rdata", {req1_rdata, req0_rdata}, 0);
        tick();
        Hresetn = 1;
        tick();

        // req0 write: setup, access, done.
        req0_valid = 1; req0_write = 1; req0_addr = 32'h8000_0010; req0_wdata = 32'hDEAD_BEEF;
        @(negedge Hclk);
        chk("t1_idle_pselx", Pselx, 0);
        @(negedge Hclk);
        chk("t1_setup_pselx", Pselx, 3'b001);
        chk("t1_setup_penable", Penable, 0);
        chk("t1_setup_pwrite", Pwrite, 1);
        chk("t1_setup_paddr", Paddr, 32'h8000_0010);
        @(negedge Hclk);
        chk("t1_access_penable", Penable, 1);
        chk("t1_access_pwdata", Pwdata, 32'hDEAD_BEEF);
        @(negedge Hclk);
        chk("t1_done0", req0_done, 1);
        chk("t1_err0", req0_err, 0);
        tick();
        req0_valid = 0;

        // req1 read from slave 1.
        xfer(1, 0, 32'h8400_0004, 32'h0, 32'h0000_00A5, 0, "t2_rd1");

        // Both continuously valid: grants alternate, no idle between transfers.
        req0_valid = 1; req0_write = 1; req0_addr = 32'h8800_0000; req0_wdata = 32'h1111_2222;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h8000_0000; req1_wdata = 32'h3333_4444;
        @(negedge Hclk);
        for (int i = 0; i < 8; i++) begin
            @(negedge Hclk);
            Prdata = 32'h1000_0000 + 32'(i);
            chk("t3_pselx", Pselx, t3_psel[i]);
            chk("t3_penable", Penable, t3_pen[i]);
            chk("t3_done0", req0_done, t3_d0[i]);
            chk("t3_done1", req1_done, t3_d1[i]);
        end
        req0_valid = 0;
        req1_valid = 0;
        repeat (4) tick();

        // Decode error and address-window boundaries.
        xfer(0, 1, 32'h9000_0000, 32'h5555_5555, 32'h0, 1, "t4_err0");
        xfer(1, 1, 32'h8BFF_FFFC, 32'h0BAD_F00D, 32'h0, 0, "t6_top_s2");
        xfer(1, 1, 32'h8C00_0000, 32'h0, 32'h0, 1, "t6_past_s2");
        xfer(0, 0, 32'h83FF_FFFF, 32'h0, 32'h0000_CAFE, 0, "t6_top_s0");
        xfer(0, 0, 32'h7FFF_FFFF, 32'h0, 32'hFFFF_FFFF, 1, "t6_below_s0");
        xfer(1, 0, 32'h8400_0000, 32'h0, 32'h0012_3456, 0, "t6_base_s1");
        repeat (2) tick();

        // Reset during ACCESS aborts the transfer; afterwards requester 0 wins first.
        req0_valid = 1; req0_write = 1; req0_addr = 32'h8400_0000; req0_wdata = 32'h7777_7777;
        repeat (3) @(negedge Hclk);
        chk("t5_access_penable", Penable, 1);
        Hresetn = 0;
        req0_valid = 0;
        @(negedge Hclk);
        chk("t5_rst_pselx", Pselx, 0);
        chk("t5_rst_penable", Penable, 0);
        chk("t5_rst_paddr", Paddr, 0);
        chk("t5_rst_done0", req0_done, 0);
        chk("t5_rst_rdata1", req1_rdata, 0);
        tick();
        Hresetn = 1;
        req0_valid = 1; req0_write = 1; req0_addr = 32'h8000_0020; req0_wdata = 32'h1234_5678;
        req1_valid = 1; req1_write = 0; req1_addr = 32'h8800_0008; req1_wdata = 32'h0;
        Prdata = 32'h5A5A_5A5A;
        @(negedge Hclk);
        @(negedge Hclk);
        chk("t5_first_pselx", Pselx, 3'b001);
        @(negedge Hclk);
        @(negedge Hclk);
        chk("t5_done0", req0_done, 1);
        chk("t5_second_pselx", Pselx, 3'b100);
        tick();
        req0_valid = 0;
        @(negedge Hclk);
        @(negedge Hclk);
        chk("t5_done1", req1_done, 1);
        chk("t5_rdata1", req1_rdata, 32'h5A5A_5A5A);
        tick();
        req1_valid = 0;
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
